// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the spiking network blocks.
// Functions take the datapath width as an argument so every layer can share them.
package snn_pkg;

  localparam int NUM_CH_DEF = 10;
  localparam int WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCAN,
    DONE
  } wta_state_t;

  // One guard bit above the operand width; clamps instead of wrapping.
  function automatic logic [32:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w
  );
    logic [32:0] s;
    logic [32:0] mx;
    mx = (33'd1 << w) - 33'd1;
    s  = {1'b0, a} + {1'b0, b};
    return (s > mx) ? mx : s;
  endfunction

  function automatic logic [31:0] leak(
    input logic [31:0] a,
    input int          sh
  );
    return (sh == 0) ? 32'd0 : (a >> sh);
  endfunction

endpackage

// File: rtl/spike_integrator.sv
// Per-channel saturating, optionally leaky spike accumulator.
// The clear input has priority so a new window always starts from zero.
module spike_integrator
  import snn_pkg::*;
#(
  parameter int WIDTH_P    = WIDTH_DEF,
  parameter int LEAK_SHIFT = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic               spike_i,
  input  logic [WIDTH_P-1:0] weight_i,
  output logic [WIDTH_P-1:0] acc_o
);

  logic [WIDTH_P-1:0] acc_q;
  logic [WIDTH_P-1:0] acc_d;
  logic [WIDTH_P-1:0] inc;
  logic [31:0]        kept;

  always_comb begin
    inc   = spike_i ? weight_i : '0;
    kept  = 32'(acc_q) - leak(32'(acc_q), LEAK_SHIFT);
    acc_d = WIDTH_P'(sat_add(kept, 32'(inc), WIDTH_P));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/wta_readout.sv
// Winner-take-all readout: integrate spikes over a window, then scan
// one channel per cycle for the maximum and hand it off on valid/ready.
module wta_readout
  import snn_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int WIDTH_P    = WIDTH_DEF,
  parameter int WINDOW     = 64,
  parameter int LEAK_SHIFT = 0,
  parameter int IDX_W      = $clog2(NUM_CH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [NUM_CH-1:0]  spike_i,
  input  logic [WIDTH_P-1:0] weight_i,
  output logic               busy_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] max_value_o,
  output logic [IDX_W-1:0]   max_index_o,
  output logic               tie_o
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

  wta_state_t         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [WIDTH_P-1:0] best_q, best_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               tie_q, tie_d;
  logic               busy_q, valid_q;
  logic [WIDTH_P-1:0] val_q;
  logic [IDX_W-1:0]   oidx_q;
  logic               otie_q;

  logic [WIDTH_P-1:0] acc [NUM_CH];
  logic [WIDTH_P-1:0] cur;
  logic               clear;
  logic               en;

  assign clear = (state_q == IDLE) && start_i;
  assign en    = (state_q == ACCUM);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    spike_integrator #(
      .WIDTH_P    (WIDTH_P),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_int (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear),
      .en_i     (en),
      .spike_i  (spike_i[g]),
      .weight_i (weight_i),
      .acc_o    (acc[g])
    );
  end

  assign cur = acc[ptr_q];

  // Strict greater-than keeps the lowest index on equal values.
  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    tie_d  = tie_q;
    if (cur > best_q) begin
      best_d = cur;
      idx_d  = ptr_q;
      tie_d  = 1'b0;
    end else if (cur == best_q && ptr_q != '0) begin
      tie_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      tie_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      val_q   <= '0;
      oidx_q  <= '0;
      otie_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ACCUM: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= SCAN;
            ptr_q   <= '0;
            best_q  <= '0;
            idx_q   <= '0;
            tie_q   <= 1'b0;
          end
        end
        SCAN: begin
          best_q <= best_d;
          idx_q  <= idx_d;
          tie_q  <= tie_d;
          ptr_q  <= ptr_q + IDX_W'(1);
          if (ptr_q == LAST_CH) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            val_q   <= best_d;
            oidx_q  <= idx_d;
            otie_q  <= tie_d;
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign max_value_o = val_q;
  assign max_index_o = oidx_q;
  assign tie_o       = otie_q;

endmodule

// File: tb/tb_wta_readout.sv
// Scoreboard bench for wta_readout: a behavioural model predicts each
// window result, and a second instance exercises the leak path.
module tb_wta_readout;

  localparam int NCH = 10;
  localparam int WIN = 8;

  typedef struct packed {
    logic [7:0] v;
    logic [3:0] i;
    logic       t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           start_i;
  logic [NCH-1:0] spike_i;
  logic [7:0]     weight_i;
  logic           ready_i;
  logic           busy;
  logic           valid;
  logic [7:0]     max_value;
  logic [3:0]     max_index;
  logic           tie;

  logic       l_start;
  logic [3:0] l_spike;
  logic [7:0] l_weight;
  logic       l_ready;
  logic       l_busy;
  logic       l_valid;
  logic [7:0] l_value;
  logic [1:0] l_index;
  logic       l_tie;

  int errors = 0;
  int checks = 0;

  logic [NCH-1:0] pat [WIN];
  exp_t sb [$];
  exp_t last_e;

  wta_readout #(
    .NUM_CH(NCH), .WIDTH_P(8), .WINDOW(WIN), .LEAK_SHIFT(0)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start_i),
    .spike_i     (spike_i),
    .weight_i    (weight_i),
    .busy_o      (busy),
    .valid_o     (valid),
    .ready_i     (ready_i),
    .max_value_o (max_value),
    .max_index_o (max_index),
    .tie_o       (tie)
  );

  wta_readout #(
    .NUM_CH(4), .WIDTH_P(8), .WINDOW(3), .LEAK_SHIFT(1)
  ) u_leak (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (l_start),
    .spike_i     (l_spike),
    .weight_i    (l_weight),
    .busy_o      (l_busy),
    .valid_o     (l_valid),
    .ready_i     (l_ready),
    .max_value_o (l_value),
    .max_index_o (l_index),
    .tie_o       (l_tie)
  );

  function automatic exp_t model(input logic [7:0] w);
    int   acc [NCH];
    exp_t e;
    for (int c = 0; c < NCH; c++) begin
      acc[c] = 0;
      for (int s = 0; s < WIN; s++) begin
        if (pat[s][c]) acc[c] += int'(w);
        if (acc[c] > 255) acc[c] = 255;
      end
    end
    e = '0;
    for (int k = 0; k < NCH; k++) begin
      if (acc[k] > int'(e.v)) begin
        e.v = 8'(acc[k]);
        e.i = 4'(k);
        e.t = 1'b0;
      end else if (acc[k] == int'(e.v) && k > 0) begin
        e.t = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic set_pat(input logic [NCH-1:0] m, input int n);
    for (int s = 0; s < WIN; s++) pat[s] = (s < n) ? m : '0;
  endtask

  // Caller sits at a negedge; start is sampled on the next posedge.
  task automatic run_window(input logic [7:0] w, input string nm);
    int   lat;
    exp_t e;
    exp_t got;
    sb.push_back(model(w));
    start_i  = 1'b1;
    weight_i = w;
    @(negedge clk);
    start_i = 1'b0;
    spike_i = pat[0];
    lat = 0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: busy=%b valid=%b, want 1 0", nm, busy, valid);
    end
    while (valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      spike_i = (lat < WIN) ? pat[lat] : '0;
    end
    checks++;
    if (lat != WIN + NCH) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, want %0d", nm, lat, WIN + NCH);
    end
    e = sb.pop_front();
    last_e = e;
    got = {max_value, max_index, tie};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s_result: got v=%0d i=%0d t=%b, want v=%0d i=%0d t=%b",
               nm, got.v, got.i, got.t, e.v, e.i, e.t);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_done: busy=%b, want 0", nm, busy);
    end
  endtask

  task automatic accept(input string nm);
    exp_t got;
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    got = {max_value, max_index, tie};
    checks++;
    if (valid !== 1'b0 || got !== last_e) begin
      errors++;
      $display("FAIL %s_accept: valid=%b v=%0d i=%0d t=%b, want 0 v=%0d i=%0d t=%b",
               nm, valid, got.v, got.i, got.t, last_e.v, last_e.i, last_e.t);
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({busy, valid, max_value, max_index, tie} !== '0) begin
      errors++;
      $display("FAIL %s_zero: busy=%b valid=%b v=%0d i=%0d t=%b, want all 0",
               nm, busy, valid, max_value, max_index, tie);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b0; spike_i = '0; weight_i = '0; ready_i = 1'b0;
    l_start = 1'b0; l_spike = '0; l_weight = '0; l_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("reset");
  endtask

  task automatic test_single();
    set_pat(NCH'(1 << 3), WIN);
    run_window(8'd5, "single");
    accept("single");
  endtask

  task automatic test_tie();
    set_pat(NCH'((1 << 2) | (1 << 7)), 4);
    run_window(8'd10, "tie");
    accept("tie");
  endtask

  task automatic test_saturate();
    set_pat(NCH'(1 << 9), WIN);
    run_window(8'd200, "saturate");
    accept("saturate");
  endtask

  task automatic test_all_zero();
    set_pat('0, WIN);
    run_window(8'd77, "all_zero");
    accept("all_zero");
  endtask

  task automatic test_backpressure();
    exp_t got;
    set_pat(NCH'(1 << 5), WIN);
    run_window(8'd3, "bp");
    for (int c = 0; c < 5; c++) begin
      start_i = (c % 2 == 0);
      @(negedge clk);
      got = {max_value, max_index, tie};
      checks++;
      if (valid !== 1'b1 || busy !== 1'b0 || got !== last_e) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b busy=%b v=%0d i=%0d, want 1 0 v=%0d i=%0d",
                 c, valid, busy, got.v, got.i, last_e.v, last_e.i);
      end
    end
    start_i = 1'b0;
    accept("bp");
    set_pat(NCH'(3), 2);
    run_window(8'd9, "bp_next");
    accept("bp_next");
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    set_pat(NCH'(1 << 8), 6);
    run_window(8'd4, "b2b");
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_len: valid=%b one cycle later, want 0", valid);
    end
    set_pat(NCH'((1 << 1) | (1 << 6)), 3);
    run_window(8'd21, "b2b2");
    ready_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_pat(NCH'(1 << 3), WIN);
    start_i = 1'b1;
    weight_i = 8'd5;
    @(negedge clk);
    start_i = 1'b0;
    spike_i = pat[0];
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_accum");
    @(negedge clk);
    rst_n = 1'b1;
    spike_i = '0;
    set_pat('0, WIN);
    run_window(8'd9, "post_rst");
    accept("post_rst");
    set_pat(NCH'(1 << 1), WIN);
    run_window(8'd7, "pre_rst_done");
    #2 rst_n = 1'b0;
    #1 check_zero("rst_done");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("rst_release");
    set_pat(NCH'((1 << 4) | (1 << 0)), 5);
    run_window(8'd11, "fresh");
    accept("fresh");
  endtask

  task automatic test_leak();
    int lat;
    l_start  = 1'b1;
    l_weight = 8'd100;
    @(negedge clk);
    l_start = 1'b0;
    l_spike = 4'b0001;
    lat = 0;
    while (l_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      l_spike = '0;
    end
    checks++;
    if (lat != 3 + 4) begin
      errors++;
      $display("FAIL leak_latency: got %0d cycles, want 7", lat);
    end
    checks++;
    if (l_value !== 8'd25 || l_index !== 2'd0 || l_tie !== 1'b0) begin
      errors++;
      $display("FAIL leak_result: got v=%0d i=%0d t=%b, want v=25 i=0 t=0",
               l_value, l_index, l_tie);
    end
    l_ready = 1'b1;
    @(negedge clk);
    l_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_leak();
    test_single();
    test_tie();
    test_saturate();
    test_all_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
